fg_waveform_meas: RTL and testbench
===================================

// Module: fg_waveform_meas
// PURPOSE
//  Measurement end of the function-generator sample stream: consumes signed waveform samples (the FG_WaveformGen
//  output format) and recovers period, ON time, peak and trough of each cycle. Dual-threshold edge detection gives
//  hysteresis. Results go to the register interface through a valid/ack handshake; used for closed-loop self-test.
// PARAMETERS
//  COUNTER_BITWIDTH   32  width of period/ON-time counters and results
//  WAVEFORM_BITWIDTH  16  sample magnitude width; samples are WAVEFORM_BITWIDTH+1 bits signed
// PORTS
//  clk_i        in   1      system clock; all state on rising edge
//  rstn_i       in   1      reset, asynchronous, active-low
//  clk_en_i     in   1      sample strobe; state/counters advance only when high
//  enable_i     in   1      measurement enable; low -> IDLE
//  sample_i     in   WB+1   signed input sample (WB = WAVEFORM_BITWIDTH)
//  lo_th_i      in   WB+1   signed low threshold; fall/re-arm at sample <= lo_th_i
//  hi_th_i      in   WB+1   signed high threshold; rise at sample >= hi_th_i (hi_th_i > lo_th_i required)
//  period_o     out  CB     cycles between consecutive rising detections (CB = COUNTER_BITWIDTH)
//  on_time_o    out  CB     cycles from rising detection to falling detection
//  peak_o       out  WB+1   signed max sample over the measured period
//  trough_o     out  WB+1   signed min sample over the measured period
//  rise_time_o  out  CB     see CONFIGURATION (0 when feature compiled out)
//  meas_valid_o out  1      result registers hold an unacknowledged result
//  meas_ack_i   in   1      consumer ack; clears meas_valid_o
//  overrun_o    out  1      sticky: unacked result overwritten; cleared by ack
//  timeout_o    out  1      sticky: period counter saturated; cleared by enable_i low
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0, peak/trough trackers = sample at first SYNC cycle.
//  - All steps below are qualified by clk_en_i, except ack handling, which acts on every clock.
//  - FSM: IDLE -> SYNC when enable_i. SYNC: wait sample <= lo_th_i -> ARM. ARM: wait sample >= hi_th_i
//    -> HIGH, clear period/ON counters, init peak=trough=sample (first edge, nothing published).
//    HIGH: count ON and period; on sample <= lo_th_i latch ON count -> LOW. LOW: count period; on
//    sample >= hi_th_i publish, restart counters, trackers = sample -> HIGH.
//  - Counters start at 1 on the cycle after detection; published period includes detection cycle
//    (square wave 5 hi/5 lo -> period 10, on_time 5).
//  - Samples strictly between thresholds never cause a transition (hysteresis).
//  - Signed compare throughout; peak/trough update every strobed cycle in HIGH/LOW.
//  - Publish: result regs load in one cycle; meas_valid_o rises same edge (latency 1 strobe after edge).
//    If meas_valid_o already high and no ack that clock -> overwrite, set overrun_o.
//    Ack and publish same clock -> new result loaded, valid stays 1, overrun_o not set.
//  - Period counter saturates at all-ones: set timeout_o, go SYNC; no publish.
//  - enable_i low (any state): next clock -> IDLE, meas_valid_o/overrun_o/timeout_o cleared, results held.
//  - rstn_i assert mid-measurement: immediate clear, no partial result published.
// CONFIGURATION
//  FG_MEAS_RISETIME_EN defined: rise_time_o = strobed cycles from first sample > lo_th_i (in LOW/ARM)
//   to rising detection, published with period; 0 if the crossing and detection fall in one sample.
//  Undefined: rise-time counter not built, rise_time_o tied 0.
// STRUCTURE
//  - Shared package fg_pkg: measurement state encoding (IDLE/SYNC/ARM/HIGH/LOW), default widths,
//    saturate-value constant shared with generator counters.
//  - Sub-module fg_meas_capture: result registers + valid/ack/overrun handshake; FSM/counters in top.
// TESTING
//  - Square 0/1000, 5 hi 5 lo, lo_th=200 hi_th=800, clk_en_i=1 -> after 2nd edge period=10 on_time=5
//    peak=1000 trough=0 valid=1.
//  - Noise 400..600 toggling each cycle between thresholds -> no transitions, meas_valid_o stays 0.
//  - Two periods published without ack -> overrun_o=1, results = 2nd period; ack -> valid=0 overrun=0.
//  - Ack in same clock as publish -> valid stays 1, overrun_o=0.
//  - COUNTER_BITWIDTH=8, constant sample 900 after edge -> timeout_o=1 after 255 strobes, state SYNC.
//  - FG_MEAS_RISETIME_EN, ramp 0->1000 step 100/strobe, lo=200 hi=800 -> rise_time_o=6; rstn_i low mid-ramp
//    -> all outputs 0 same cycle.

Source files
------------

// File: rtl/fg_pkg.sv
// Shared function-generator definitions: measurement FSM encoding, default widths, counter saturation value.
package fg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_ARM,
        ST_HIGH,
        ST_LOW
    } meas_state_e;

    localparam int FG_CB_DEFAULT = 32;
    localparam int FG_WB_DEFAULT = 16;

    // Counters saturate at all-ones; slice to the counter width at the point of use.
    localparam logic [63:0] FG_SAT_ALL_ONES = '1;

endpackage

// File: rtl/fg_waveform_meas_if.sv
// Result bus of the waveform measurement block: result registers, valid/ack handshake, sticky flags.
interface fg_waveform_meas_if #(
    parameter int COUNTER_BITWIDTH  = 32,
    parameter int WAVEFORM_BITWIDTH = 16
);
    logic        [COUNTER_BITWIDTH-1:0] period_o;
    logic        [COUNTER_BITWIDTH-1:0] on_time_o;
    logic        [COUNTER_BITWIDTH-1:0] rise_time_o;
    logic signed [WAVEFORM_BITWIDTH:0]  peak_o;
    logic signed [WAVEFORM_BITWIDTH:0]  trough_o;
    logic                               meas_valid_o;
    logic                               meas_ack_i;
    logic                               overrun_o;
    logic                               timeout_o;

    modport master (
        output period_o, on_time_o, rise_time_o, peak_o, trough_o,
        output meas_valid_o, overrun_o, timeout_o,
        input  meas_ack_i
    );

    modport slave (
        input  period_o, on_time_o, rise_time_o, peak_o, trough_o,
        input  meas_valid_o, overrun_o, timeout_o,
        output meas_ack_i
    );
endinterface

// File: rtl/fg_meas_capture.sv
// Result registers and valid/ack/overrun handshake; loads in the publish cycle, ack acts on every clock.
// No backpressure: a publish onto an unacked result overwrites it and raises the sticky overrun flag.
module fg_meas_capture
    import fg_pkg::*;
#(
    parameter int COUNTER_BITWIDTH  = FG_CB_DEFAULT,
    parameter int WAVEFORM_BITWIDTH = FG_WB_DEFAULT
) (
    input  logic                                clk_i,
    input  logic                                rstn_i,
    input  logic                                clear_i,
    input  logic                                publish_i,
    input  logic        [COUNTER_BITWIDTH-1:0]  period_i,
    input  logic        [COUNTER_BITWIDTH-1:0]  on_time_i,
    input  logic        [COUNTER_BITWIDTH-1:0]  rise_time_i,
    input  logic signed [WAVEFORM_BITWIDTH:0]   peak_i,
    input  logic signed [WAVEFORM_BITWIDTH:0]   trough_i,
    fg_waveform_meas_if.master                  res
);
    logic                               valid_q, valid_d;
    logic                               ovr_q, ovr_d;
    logic                               load;
    logic        [COUNTER_BITWIDTH-1:0] period_q, on_time_q, rise_q;
    logic signed [WAVEFORM_BITWIDTH:0]  peak_q, trough_q;

    assign load = publish_i && !clear_i;

    always_comb begin
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (clear_i) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else if (publish_i) begin
            // An ack landing with the publish consumes the old result, so no overrun.
            valid_d = 1'b1;
            ovr_d   = res.meas_ack_i ? 1'b0 : (ovr_q | valid_q);
        end else if (res.meas_ack_i) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
            period_q  <= '0;
            on_time_q <= '0;
            rise_q    <= '0;
            peak_q    <= '0;
            trough_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            if (load) begin
                period_q  <= period_i;
                on_time_q <= on_time_i;
                rise_q    <= rise_time_i;
                peak_q    <= peak_i;
                trough_q  <= trough_i;
            end
        end
    end

    assign res.meas_valid_o = valid_q;
    assign res.overrun_o    = ovr_q;
    assign res.period_o     = period_q;
    assign res.on_time_o    = on_time_q;
    assign res.rise_time_o  = rise_q;
    assign res.peak_o       = peak_q;
    assign res.trough_o     = trough_q;

endmodule

// File: rtl/fg_waveform_meas.sv
// Hysteretic period/ON-time/peak/trough measurement of a signed sample stream; result 1 strobe after rising edge.
// No backpressure (unacked results overwritten, overrun flagged). FG_MEAS_RISETIME_EN builds the rise-time counter.
module fg_waveform_meas
    import fg_pkg::*;
#(
    parameter int COUNTER_BITWIDTH  = FG_CB_DEFAULT,
    parameter int WAVEFORM_BITWIDTH = FG_WB_DEFAULT
) (
    input  logic                              clk_i,
    input  logic                              rstn_i,
    input  logic                              clk_en_i,
    input  logic                              enable_i,
    input  logic signed [WAVEFORM_BITWIDTH:0] sample_i,
    input  logic signed [WAVEFORM_BITWIDTH:0] lo_th_i,
    input  logic signed [WAVEFORM_BITWIDTH:0] hi_th_i,
    fg_waveform_meas_if.master                res
);
    localparam int            CB  = COUNTER_BITWIDTH;
    localparam int            WB  = WAVEFORM_BITWIDTH;
    localparam logic [CB-1:0] SAT = FG_SAT_ALL_ONES[CB-1:0];

    meas_state_e         state_q, state_d;
    logic        [CB-1:0] per_q, per_d, on_q, on_d, rise_pub;
    logic signed [WB:0]   pk_q, pk_d, tr_q, tr_d;
    logic                 tmo_q, tmo_d, publish, above_hi, below_lo;

    assign above_hi = sample_i >= hi_th_i;
    assign below_lo = sample_i <= lo_th_i;

    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        on_d    = on_q;
        pk_d    = pk_q;
        tr_d    = tr_q;
        tmo_d   = tmo_q;
        publish = 1'b0;
        if (!enable_i) begin
            state_d = ST_IDLE;
            tmo_d   = 1'b0;
        end else if (clk_en_i) begin
            case (state_q)
                ST_IDLE: state_d = ST_SYNC;
                ST_SYNC: begin
                    pk_d = sample_i;
                    tr_d = sample_i;
                    if (below_lo) state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (above_hi) begin
                        state_d = ST_HIGH;
                        per_d   = CB'(1);
                        pk_d    = sample_i;
                        tr_d    = sample_i;
                    end
                end
                ST_HIGH, ST_LOW: begin
                    pk_d = (sample_i > pk_q) ? sample_i : pk_q;
                    tr_d = (sample_i < tr_q) ? sample_i : tr_q;
                    if (per_q == SAT) begin
                        tmo_d   = 1'b1;
                        state_d = ST_SYNC;
                    end else if (state_q == ST_HIGH && below_lo) begin
                        // ON and period counters run together from the rise, so ON is a period snapshot.
                        on_d    = per_q;
                        per_d   = per_q + 1'b1;
                        state_d = ST_LOW;
                    end else if (state_q == ST_LOW && above_hi) begin
                        publish = 1'b1;
                        per_d   = CB'(1);
                        pk_d    = sample_i;
                        tr_d    = sample_i;
                        state_d = ST_HIGH;
                    end else begin
                        per_d = per_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            per_q   <= '0;
            on_q    <= '0;
            pk_q    <= '0;
            tr_q    <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            on_q    <= on_d;
            pk_q    <= pk_d;
            tr_q    <= tr_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef FG_MEAS_RISETIME_EN
    logic          rise_run_q, rise_run_d;
    logic [CB-1:0] rise_cnt_q, rise_cnt_d;

    // Count includes both the first sample above lo_th and the detection sample; 0 when they coincide.
    assign rise_pub = rise_run_q ? rise_cnt_q + 1'b1 : '0;

    always_comb begin
        rise_run_d = rise_run_q;
        rise_cnt_d = rise_cnt_q;
        if (!enable_i) begin
            rise_run_d = 1'b0;
        end else if (clk_en_i) begin
            if ((state_q == ST_ARM || state_q == ST_LOW) && !above_hi) begin
                if (below_lo) begin
                    rise_run_d = 1'b0;
                end else if (!rise_run_q) begin
                    rise_run_d = 1'b1;
                    rise_cnt_d = CB'(1);
                end else begin
                    rise_cnt_d = rise_cnt_q + 1'b1;
                end
            end else begin
                rise_run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rise_run_q <= 1'b0;
            rise_cnt_q <= '0;
        end else begin
            rise_run_q <= rise_run_d;
            rise_cnt_q <= rise_cnt_d;
        end
    end
`else
    assign rise_pub = '0;
`endif

    fg_meas_capture #(
        .COUNTER_BITWIDTH  (CB),
        .WAVEFORM_BITWIDTH (WB)
    ) u_capture (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .clear_i     (!enable_i),
        .publish_i   (publish),
        .period_i    (per_q),
        .on_time_i   (on_q),
        .rise_time_i (rise_pub),
        .peak_i      (pk_q),
        .trough_i    (tr_q),
        .res         (res)
    );

    assign res.timeout_o = tmo_q;

endmodule

// File: tb/tb_fg_waveform_meas.sv
// Directed bench: a 32-bit and an 8-bit counter instance share stimulus; expectations are hand-computed.
module tb_fg_waveform_meas;

    logic              clk = 1'b0;
    logic              rstn, clk_en, enable, ack;
    logic signed [16:0] sample, lo_th, hi_th;
    int                vec = 0;
    int                miss = 0;
    logic [63:0]       exp_rise;

    fg_waveform_meas_if #(.COUNTER_BITWIDTH(32), .WAVEFORM_BITWIDTH(16)) m_if ();
    fg_waveform_meas_if #(.COUNTER_BITWIDTH(8),  .WAVEFORM_BITWIDTH(16)) s_if ();

    assign m_if.meas_ack_i = ack;
    assign s_if.meas_ack_i = ack;

    fg_waveform_meas #(.COUNTER_BITWIDTH(32), .WAVEFORM_BITWIDTH(16)) dut (
        .clk_i(clk), .rstn_i(rstn), .clk_en_i(clk_en), .enable_i(enable),
        .sample_i(sample), .lo_th_i(lo_th), .hi_th_i(hi_th), .res(m_if)
    );

    fg_waveform_meas #(.COUNTER_BITWIDTH(8), .WAVEFORM_BITWIDTH(16)) dut8 (
        .clk_i(clk), .rstn_i(rstn), .clk_en_i(clk_en), .enable_i(enable),
        .sample_i(sample), .lo_th_i(lo_th), .hi_th_i(hi_th), .res(s_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // From just after a rising detection: h high samples in total (detection included), l low samples.
    task automatic run(input int h, input int l, input int lo_val);
        repeat (h - 1) begin sample = 17'sd1000; tick(); end
        repeat (l) begin sample = 17'(lo_val); tick(); end
        sample = 17'sd1000;
    endtask

    initial begin
`ifdef FG_MEAS_RISETIME_EN
        exp_rise = 64'd6;
`else
        exp_rise = 64'd0;
`endif
        rstn = 1'b0; clk_en = 1'b1; enable = 1'b0; ack = 1'b0;
        sample = '0; lo_th = 17'sd200; hi_th = 17'sd800;
        tick(); tick();
        chk("rst_valid",   m_if.meas_valid_o, 0);
        chk("rst_period",  m_if.period_o, 0);
        chk("rst_peak",    m_if.peak_o, 0);
        chk("rst_overrun", m_if.overrun_o, 0);
        chk("rst_timeout", m_if.timeout_o, 0);
        chk("rst_rise",    m_if.rise_time_o, 0);
        rstn = 1'b1;

        // Square 0/1000: IDLE->SYNC->ARM, first edge publishes nothing.
        enable = 1'b1;
        tick(); tick(); tick();
        sample = 17'sd1000; tick();
        chk("first_edge_no_valid", m_if.meas_valid_o, 0);
        run(5, 5, 0); tick();
        chk("sq_valid",   m_if.meas_valid_o, 1);
        chk("sq_period",  m_if.period_o, 10);
        chk("sq_on",      m_if.on_time_o, 5);
        chk("sq_peak",    m_if.peak_o, 1000);
        chk("sq_trough",  m_if.trough_o, 0);
        chk("sq_overrun", m_if.overrun_o, 0);
        chk("sq_rise0",   m_if.rise_time_o, 0);
        chk("sq_period8", s_if.period_o, 10);

        ack = 1'b1; tick(); ack = 1'b0;
        chk("ack_valid", m_if.meas_valid_o, 0);
        run(4, 5, 0); tick();
        chk("p2_valid",   m_if.meas_valid_o, 1);
        chk("p2_overrun", m_if.overrun_o, 0);

        // Second publish without ack overwrites and flags overrun; negative trough.
        run(3, 6, -50); tick();
        chk("ovr_valid",   m_if.meas_valid_o, 1);
        chk("ovr_flag",    m_if.overrun_o, 1);
        chk("ovr_period",  m_if.period_o, 9);
        chk("ovr_on",      m_if.on_time_o, 3);
        chk("ovr_trough",  m_if.trough_o, -50);
        chk("ovr_peak",    m_if.peak_o, 1000);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("ovr_ack_valid", m_if.meas_valid_o, 0);
        chk("ovr_ack_flag",  m_if.overrun_o, 0);

        run(4, 5, 0); tick();
        chk("p4_valid", m_if.meas_valid_o, 1);
        run(5, 5, 0); ack = 1'b1; tick(); ack = 1'b0;
        chk("ackpub_valid",   m_if.meas_valid_o, 1);
        chk("ackpub_overrun", m_if.overrun_o, 0);
        chk("ackpub_period",  m_if.period_o, 10);

        enable = 1'b0; tick();
        chk("dis_valid",  m_if.meas_valid_o, 0);
        chk("dis_period_held", m_if.period_o, 10);

        // Noise strictly between thresholds in HIGH and LOW; exact-threshold samples do switch.
        enable = 1'b1; sample = '0;
        tick(); tick(); tick();
        sample = 17'sd1000; tick();
        for (int i = 0; i < 20; i++) begin sample = (i % 2 == 0) ? 17'sd400 : 17'sd600; tick(); end
        sample = 17'sd200; tick();
        for (int i = 0; i < 20; i++) begin sample = (i % 2 == 0) ? 17'sd600 : 17'sd400; tick(); end
        chk("noise_no_valid", m_if.meas_valid_o, 0);
        sample = 17'sd800; tick();
        chk("thr_valid",  m_if.meas_valid_o, 1);
        chk("thr_period", m_if.period_o, 42);
        chk("thr_on",     m_if.on_time_o, 21);
        chk("thr_trough", m_if.trough_o, 200);

        // Hold high: the 8-bit instance saturates its period counter.
        ack = 1'b1; sample = 17'sd900; tick(); ack = 1'b0;
        repeat (253) tick();
        chk("tmo_not_yet", s_if.timeout_o, 0);
        tick();
        chk("tmo_set8",   s_if.timeout_o, 1);
        chk("tmo_clear32", m_if.timeout_o, 0);
        chk("tmo_no_pub", s_if.meas_valid_o, 0);
        enable = 1'b0; tick();
        chk("tmo_dis_clear", s_if.timeout_o, 0);

        // Ramp up / down / up: second rising detection publishes.
        enable = 1'b1; sample = '0;
        tick(); tick(); tick();
        for (int v = 0; v <= 1000; v += 100) begin sample = 17'(v); tick(); end
        for (int v = 900; v >= 0; v -= 100) begin sample = 17'(v); tick(); end
        for (int v = 100; v <= 800; v += 100) begin sample = 17'(v); tick(); end
        chk("ramp_valid",  m_if.meas_valid_o, 1);
        chk("ramp_period", m_if.period_o, 20);
        chk("ramp_on",     m_if.on_time_o, 10);
        chk("ramp_rise",   m_if.rise_time_o, exp_rise);

        sample = 17'sd900; tick();
        sample = 17'sd700; tick();
        rstn = 1'b0; #1;
        chk("arst_valid",  m_if.meas_valid_o, 0);
        chk("arst_period", m_if.period_o, 0);
        chk("arst_on",     m_if.on_time_o, 0);
        chk("arst_peak",   m_if.peak_o, 0);
        chk("arst_rise",   m_if.rise_time_o, 0);
        rstn = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
